mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single memory port,
// with bounded data priority so a waiting fetch cannot starve indefinitely.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        grant_id,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t      state, state_nx;
  logic [2:0]  starve_cnt, starve_nx;

  logic        if_ack_nx, d_ack_nx, mem_en_nx, mem_we_nx, busy_nx;
  logic        grant_id_nx, addr_err_nx;
  logic [31:0] if_rdata_nx, d_rdata_nx, mem_addr_nx, mem_wdata_nx;

  logic        d_wins, grant_d, grant_if, done;

  // Priority is decided on the raw requests; a requester whose ack is high is
  // masked afterwards, so masking data never hands its winning slot to fetch.
  assign d_wins   = d_req & (~if_req | (starve_cnt < LIMIT));
  assign grant_d  = (state == IDLE) & d_wins & ~d_ack;
  assign grant_if = (state == IDLE) & ~d_wins & if_req & ~if_ack;
  assign done     = (state != IDLE) & mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      if_ack     <= if_ack_nx;
      d_ack      <= d_ack_nx;
      if_rdata   <= if_rdata_nx;
      d_rdata    <= d_rdata_nx;
      mem_en     <= mem_en_nx;
      mem_we     <= mem_we_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      busy       <= busy_nx;
      grant_id   <= grant_id_nx;
      addr_err   <= addr_err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    starve_nx = starve_cnt;
    unique case (state)
      IDLE: begin
        if (grant_d)       state_nx = D_ACC;
        else if (grant_if) state_nx = IF_ACC;
      end
      IF_ACC, D_ACC: begin
        if (mem_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (grant_if)
      starve_nx = '0;
    else if (grant_d && if_req && (starve_cnt < LIMIT))
      starve_nx = starve_cnt + 3'd1;
  end

  always_comb begin
    if_ack_nx    = 1'b0;
    d_ack_nx     = 1'b0;
    if_rdata_nx  = if_rdata;
    d_rdata_nx   = d_rdata;
    mem_en_nx    = mem_en;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    busy_nx      = busy;
    grant_id_nx  = grant_id;
    addr_err_nx  = addr_err;
    if (grant_d) begin
      mem_en_nx    = 1'b1;
      busy_nx      = 1'b1;
      grant_id_nx  = 1'b1;
      mem_we_nx    = d_we;
      mem_addr_nx  = {d_addr[31:2], 2'b00};
      mem_wdata_nx = d_we ? d_wdata : '0;
      addr_err_nx  = addr_err | (|d_addr[1:0]);
    end else if (grant_if) begin
      mem_en_nx    = 1'b1;
      busy_nx      = 1'b1;
      grant_id_nx  = 1'b0;
      mem_we_nx    = 1'b0;
      mem_addr_nx  = {if_addr[31:2], 2'b00};
      mem_wdata_nx = '0;
      addr_err_nx  = addr_err | (|if_addr[1:0]);
    end else if (done) begin
      mem_en_nx = 1'b0;
      mem_we_nx = 1'b0;
      busy_nx   = 1'b0;
      if (state == IF_ACC) begin
        if_ack_nx   = 1'b1;
        if_rdata_nx = mem_rdata;
      end else begin
        d_ack_nx = 1'b1;
        if (!mem_we) d_rdata_nx = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: expected grants and read data
// are queued as requests are driven and retired as the memory side completes.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, busy, grant_id, addr_err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  typedef struct {
    logic        gid;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned total = 0;
  int unsigned passed = 0;
  int          cyc = 0;
  int          ack_cyc = 0;
  int          t0;
  logic [31:0] exp_if = '0;
  logic [31:0] exp_d = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .grant_id(grant_id), .addr_err(addr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, 32'({mem_en, mem_we, busy, grant_id, if_ack, d_ack}), 32'd0);
    check({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    check({tag, "_rdata"}, if_rdata | d_rdata, 32'd0);
    check({tag, "_mem_bus"}, mem_addr | mem_wdata, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    exp_if = '0;
    exp_d  = '0;
    rst_n  = 1'b1;
  endtask

  // Wait (bounded) for a grant, check it against the queue head, answer after
  // 'delay' extra cycles, then check the completion and the single-cycle ack.
  task automatic serve(input int unsigned delay, input bit drop);
    exp_t        e;
    int unsigned n;
    n = 0;
    while (mem_en !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (mem_en !== 1'b1) begin
      check("grant_timeout", 32'(mem_en), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    if (drop) begin
      if_req = 1'b0;
      d_req  = 1'b0;
    end
    check("grant_id", 32'(grant_id), 32'(e.gid));
    check("busy", 32'(busy), 32'd1);
    check("mem_addr", mem_addr, e.addr);
    check("mem_we", 32'(mem_we), 32'(e.we));
    check("mem_wdata", mem_wdata, e.wdata);
    for (int unsigned i = 0; i < delay; i++) begin
      @(negedge clk);
      check("mem_en_hold", 32'(mem_en), 32'd1);
      check("mem_addr_hold", mem_addr, e.addr);
      check("ack_early", 32'({if_ack, d_ack}), 32'd0);
    end
    mem_rdata = e.rdata;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    ack_cyc = cyc;
    if (e.gid) begin
      if (!e.we) exp_d = e.rdata;
      check("ack_data", 32'({if_ack, d_ack}), 32'd1);
    end else begin
      exp_if = e.rdata;
      check("ack_fetch", 32'({if_ack, d_ack}), 32'd2);
    end
    check("if_rdata", if_rdata, exp_if);
    check("d_rdata", d_rdata, exp_d);
    check("done_clr", 32'({mem_en, mem_we, busy}), 32'd0);
    @(negedge clk);
    check("ack_pulse", 32'({if_ack, d_ack}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    do_reset();

    // Fetch only, fastest memory response
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40; t0 = cyc;
    exp_q.push_back('{gid:1'b0, addr:32'h40, we:1'b0, wdata:32'h0, rdata:32'h2008_0005});
    serve(0, 1'b1);
    check("fetch_latency", 32'(ack_cyc - t0), 32'd2);

    // Store with mem_ready delayed 3 cycles; d_rdata must not capture
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    exp_q.push_back('{gid:1'b1, addr:32'h100, we:1'b1, wdata:32'hDEAD_BEEF, rdata:32'h1234_5678});
    serve(3, 1'b1);
    check("store_no_err", 32'(addr_err), 32'd0);

    // Misaligned load, then an aligned fetch: addr_err is sticky
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h103; d_wdata = 32'hFFFF_FFFF;
    exp_q.push_back('{gid:1'b1, addr:32'h100, we:1'b0, wdata:32'h0, rdata:32'hCAFE_F00D});
    serve(1, 1'b1);
    check("addr_err_set", 32'(addr_err), 32'd1);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    exp_q.push_back('{gid:1'b0, addr:32'h200, we:1'b0, wdata:32'h0, rdata:32'h0BAD_F00D});
    serve(0, 1'b1);
    check("addr_err_sticky", 32'(addr_err), 32'd1);
    do_reset();

    // Contention: both requests held, starvation limit 4
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h400;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4)
        exp_q.push_back('{gid:1'b0, addr:32'h400, we:1'b0, wdata:32'h0, rdata:32'hA000_0000 + 32'(i)});
      else
        exp_q.push_back('{gid:1'b1, addr:32'h300, we:1'b0, wdata:32'h0, rdata:32'hB000_0000 + 32'(i)});
    end
    for (int i = 0; i < 10; i++) serve(0, i == 9);
    repeat (2) @(negedge clk);
    check("contention_quiet", 32'({mem_en, busy}), 32'd0);

    // Reset in the middle of a store
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h55AA_55AA;
    for (int n = 0; n < 30 && mem_en !== 1'b1; n++) @(negedge clk);
    d_req = 1'b0;
    check("midrst_active", 32'(mem_en), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("midrst_async", 32'({mem_en, busy, mem_we}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_ack", 32'({if_ack, d_ack}), 32'd0);
    end
    rst_n = 1'b1;
    exp_if = '0;
    exp_d  = '0;
    @(negedge clk);
    check("midrst_idle", 32'({mem_en, busy, if_ack, d_ack}), 32'd0);
    if_req = 1'b1; if_addr = 32'h80;
    exp_q.push_back('{gid:1'b0, addr:32'h80, we:1'b0, wdata:32'h0, rdata:32'h1357_9BDF});
    serve(2, 1'b1);

    // Stray mem_ready while idle
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    repeat (3) begin
      @(negedge clk);
      check("stray_ready", 32'({if_ack, d_ack, busy, mem_en}), 32'd0);
    end
    mem_ready = 1'b0;
    check("stray_rdata_hold", if_rdata, exp_if);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
